unidade_execucao: RTL

UNIDADE_EXECUCAO -- requirements
Module: unidade_execucao

---
 rtl/unidade_execucao.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/unidade_execucao.sv
// unidade_execucao: four-state execution unit (IDLE/READ/EXEC/WRITE) driving a 4-entry register bank.
// Optional macro FLAGS_EN builds the zero/carry flag registers; undefined leaves both flags tied to 0.
module unidade_execucao #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            instr_valid,
    input  logic [7:0]      instr,
    input  logic [Size-1:0] imm,
    output logic            instr_ready,
    input  logic [Size-1:0] rd1,
    input  logic [Size-1:0] rd2,
    output logic            we,
    output logic [Size-1:0] wd,
    output logic [1:0]      a1,
    output logic [1:0]      a2,
    output logic            done,
    output logic            zero,
    output logic            carry
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    logic [1:0]      r_state;
    logic [5:0]      r_instr;
    logic [Size-1:0] r_imm;
    logic [Size-1:0] r_a;
    logic [Size-1:0] r_b;
    logic [Size-1:0] r_result;

    logic [1:0]      w_op;
    logic [1:0]      w_dest;
    logic [1:0]      w_src;
    logic [Size:0]   w_sum;
    logic [Size:0]   w_diff;
    logic [Size-1:0] w_result;
    logic            w_carry;
    logic            w_xfer;
    logic            w_unused;

    assign w_op     = r_instr[5:4];
    assign w_dest   = r_instr[3:2];
    assign w_src    = r_instr[1:0];
    assign w_xfer   = instr_valid && (r_state == IDLE);
    assign w_unused = &{1'b0, instr[1:0]};
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};

    // State sequencing: one state per cycle once an instruction is taken
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE:    r_state <= w_xfer ? READ : IDLE;
                READ:    r_state <= EXEC;
                EXEC:    r_state <= WRITE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath registers: instruction on transfer, operands in READ, result in EXEC
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_instr  <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_xfer) begin
                r_instr <= instr[7:2];
                r_imm   <= imm;
            end
            if (r_state == READ) begin
                r_a <= rd1;
                r_b <= rd2;
            end
            if (r_state == EXEC) begin
                r_result <= w_result;
            end
        end
    end

    // ALU: result and carry/borrow for the latched opcode
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_result = w_sum[Size-1:0];
                w_carry  = w_sum[Size];
            end
            OP_SUB: begin
                w_result = w_diff[Size-1:0];
                w_carry  = w_diff[Size];
            end
            OP_AND: begin
                w_result = r_a & r_b;
                w_carry  = 1'b0;
            end
            default: begin
                w_result = r_imm;
                w_carry  = 1'b0;
            end
        endcase
    end

`ifdef FLAGS_EN
    logic r_zero;
    logic r_carry;

    // Flags follow ALU ops at the end of EXEC; LDI leaves them alone
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (r_state == EXEC && w_op != OP_LDI) begin
            r_zero  <= (w_result == '0);
            r_carry <= w_carry;
        end
    end

    assign zero  = r_zero;
    assign carry = r_carry;
`else
    assign zero  = 1'b0;
    assign carry = 1'b0;
`endif

    // Bank-side outputs decoded from the current state only
    always_comb begin
        instr_ready = 1'b0;
        we          = 1'b0;
        done        = 1'b0;
        wd          = '0;
        a1          = 2'd0;
        a2          = 2'd0;
        unique case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
            end
            READ: begin
                a1 = w_dest;
                a2 = w_src;
            end
            WRITE: begin
                we   = 1'b1;
                done = 1'b1;
                a1   = w_dest;
                wd   = r_result;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

endmodule
